aes_byte_loader: RTL

Byte-serial front/back end for the AES-128 encryption pipeline. It assembles a 128-bit key and a 128-bit plaintext block from an 8-bit valid/ready stream and drives them, held stable, onto the pipeline's `Data_in`/`key_in`. It waits the pipeline's fixed latency, captures `cipher_out`, and returns the ciphertext as a 16-byte valid/ready stream. One block is in flight at a time. The key is retained across blocks until it is reloaded.

---
 rtl/aes_byte_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aes_byte_loader.sv
// aes_byte_loader
// Byte-serial front/back end for a fixed-latency AES-128 pipeline. Key and
// plaintext bytes arrive MSB-first on an 8-bit valid/ready stream and are
// shifted into 128-bit registers that drive the pipeline directly. Once the
// block is complete the loader counts LATENCY edges, captures the ciphertext
// and streams it back out MSB-first. One block is in flight at a time; the
// key is kept across blocks until a new key byte arrives.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (clears key as well)
//   in_valid   - in_byte valid
//   in_ready   - loader accepts in_byte this cycle
//   in_byte    - key/plaintext byte, most significant first
//   in_is_key  - 1: key byte, 0: plaintext byte
//   aes_data   - plaintext to the pipeline Data_in
//   aes_key    - key to the pipeline key_in
//   aes_cipher - pipeline cipher_out
//   out_valid  - out_byte valid
//   out_ready  - sink accepts out_byte
//   out_byte   - ciphertext byte, most significant first
//   busy       - a block is waiting on the pipeline or draining
module aes_byte_loader #(
  parameter int LATENCY = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_is_key,
  output logic [127:0] aes_data,
  output logic [127:0] aes_key,
  input  logic [127:0] aes_cipher,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         busy
);

  localparam int WCW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [WCW-1:0] LAT_W = WCW'(LATENCY);

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  state_t         state_q;
  logic [4:0]     data_cnt_q;
  logic [4:0]     key_cnt_q;
  logic           key_full_q;
  logic [127:0]   data_sr_q;
  logic [127:0]   key_sr_q;
  logic [WCW-1:0] wait_cnt_q;
  logic [127:0]   out_sr_q;
  logic [4:0]     out_cnt_q;
  logic           out_valid_q;
  logic           busy_q;
  logic           accept;

  // A full data register stalls further plaintext, but key bytes may still
  // complete the key; this is the only combinational input-to-output path.
  assign in_ready = (state_q == FILL) && !((data_cnt_q == 5'd16) && !in_is_key);
  assign accept   = in_valid && in_ready;

  assign aes_data  = data_sr_q;
  assign aes_key   = key_sr_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_sr_q[127:120];
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      data_cnt_q  <= 5'd0;
      key_cnt_q   <= 5'd0;
      key_full_q  <= 1'b0;
      data_sr_q   <= 128'd0;
      key_sr_q    <= 128'd0;
      wait_cnt_q  <= '0;
      out_sr_q    <= 128'd0;
      out_cnt_q   <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept && in_is_key) begin
            key_sr_q <= {key_sr_q[119:0], in_byte};
            // A key byte arriving after a complete key starts a new key.
            if (key_full_q) begin
              key_cnt_q  <= 5'd1;
              key_full_q <= 1'b0;
            end else begin
              key_cnt_q <= key_cnt_q + 5'd1;
              if (key_cnt_q == 5'd15) key_full_q <= 1'b1;
            end
          end
          if (accept && !in_is_key) begin
            data_sr_q  <= {data_sr_q[119:0], in_byte};
            data_cnt_q <= data_cnt_q + 5'd1;
          end
          // Decided on registered counts, so this lands one edge after the
          // final byte; the pipeline inputs are settled from that edge on.
          if ((data_cnt_q == 5'd16) && key_full_q) begin
            state_q    <= WAIT;
            wait_cnt_q <= WCW'(1);
            busy_q     <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt_q == LAT_W) begin
            out_sr_q    <= aes_cipher;
            out_cnt_q   <= 5'd0;
            wait_cnt_q  <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_sr_q  <= {out_sr_q[119:0], 8'd0};
            out_cnt_q <= out_cnt_q + 5'd1;
            // Key state is deliberately left alone so it can be reused.
            if (out_cnt_q == 5'd15) begin
              data_cnt_q  <= 5'd0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= FILL;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
